// File: rtl/image_uart_tx.sv
// Image read-out over UART. Reads an H x W byte image from data memory and sends it as 8N1
// frames, one frame per byte. Each byte is fetched with one READ cycle and one WAIT cycle.
// All outputs are registered and computed from next-state values, so the serial line is
// glitch-free and reset forces it high immediately.
`timescale 1ns/1ps

module image_uart_tx #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [7:0]        i_h,
    input  logic [7:0]        i_w,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_r_en,
    input  logic [7:0]        i_mem_data,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("image_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       total_q, total_d;
    logic [15:0]       idx_q, idx_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ren_q, ren_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [15:0]       start_total;
    logic              baud_last;

    assign start_total = 16'(i_h) * 16'(i_w);
    assign baud_last   = (baud_q == BAUD_LAST);

    // Sequencing: fetch, serialise and advance through the image; baud counter clears on
    // every state change and at each bit boundary.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        total_d = total_q;
        idx_d   = idx_q;
        baud_d  = '0;
        bit_d   = bit_q;
        shift_d = shift_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    base_d  = i_base_addr;
                    total_d = start_total;
                    idx_d   = '0;
                    state_d = (start_total == 16'd0) ? StDone : StRead;
                end
            end
            StRead: begin
                state_d = StWait;
            end
            StWait: begin
                shift_d = i_mem_data;
                state_d = StStart;
            end
            StStart: begin
                if (baud_last) begin
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    if (idx_q == total_q - 16'd1) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = StRead;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next-state: derived from the upcoming state so outputs align with it.
    always_comb begin
        tx_d   = 1'b1;
        ren_d  = 1'b0;
        addr_d = addr_q;
        busy_d = 1'b0;
        done_d = 1'b0;

        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        if (state_d == StRead) begin
            ren_d  = 1'b1;
            // Base plus index wraps naturally at the address width.
            addr_d = base_d + ADDR_W'(idx_d);
        end

        busy_d = (state_d == StRead) || (state_d == StWait) || (state_d == StStart) ||
                 (state_d == StData) || (state_d == StStop);
        done_d = (state_d == StDone);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            total_q <= '0;
            idx_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            ren_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            total_q <= total_d;
            idx_q   <= idx_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            ren_q   <= ren_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_mem_addr = addr_q;
    assign o_mem_r_en = ren_q;
    assign o_tx       = tx_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_image_uart_tx.sv
// Bench for image_uart_tx: 10 clocks per bit, memory returns addr[7:0] ^ 8'hA5.
`timescale 1ns/1ps

module tb_image_uart_tx;

    localparam int unsigned FRAME_PERIOD = 102;  // 100 frame clocks + READ + WAIT

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [7:0]  i_h = '0;
    logic [7:0]  i_w = '0;
    logic [7:0]  i_mem_data = '0;
    logic [31:0] o_mem_addr;
    logic        o_mem_r_en;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    image_uart_tx #(
        .CLK_FREQ(100),
        .BAUD    (10),
        .ADDR_W  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .i_h        (i_h),
        .i_w        (i_w),
        .o_mem_addr (o_mem_addr),
        .o_mem_r_en (o_mem_r_en),
        .i_mem_data (i_mem_data),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [7:0]  h;
        logic [7:0]  w;
        int          mode;       // 0 plain, 1 extra start mid-transfer, 2 start on DONE cycle
        int unsigned exp_n;      // expected frame count
        logic [7:0]  exp_first;  // expected first decoded byte
    } vec_t;

    int total = 0;
    int bad = 0;

    int unsigned cyc = 0;
    int unsigned frame_cnt = 0;
    int unsigned rd_cnt = 0;
    int unsigned busy_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;

    logic [7:0]  exp_byte_q[$];
    logic [31:0] exp_addr_q[$];
    logic [7:0]  rx_q[$];
    int unsigned fstart_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    // Synchronous read memory model.
    initial begin
        forever begin
            @(posedge clk);
            if (o_mem_r_en) i_mem_data <= o_mem_addr[7:0] ^ 8'hA5;
        end
    end

    // Line monitor: decodes frames, checks read addresses, counts busy and done cycles.
    initial begin
        bit          mon_act;
        int          mon_cnt;
        logic [7:0]  mon_byte;
        mon_act  = 1'b0;
        mon_cnt  = 0;
        mon_byte = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_act = 1'b0;
            end else begin
                if (o_mem_r_en) begin
                    rd_cnt++;
                    if (exp_addr_q.size() == 0) check("unexpected_read", o_mem_addr, 32'hx);
                    else check("read_addr", o_mem_addr, exp_addr_q.pop_front());
                end
                if (o_busy) busy_cnt++;
                if (o_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (!mon_act) begin
                    if (o_tx == 1'b0) begin
                        mon_act = 1'b1;
                        mon_cnt = 0;
                        fstart_q.push_back(cyc);
                    end
                end else begin
                    mon_cnt++;
                    if (mon_cnt == 5) begin
                        check("start_bit", 32'(o_tx), 32'd0);
                    end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
                        mon_byte[(mon_cnt - 15) / 10] = o_tx;
                    end else if (mon_cnt == 95) begin
                        frame_cnt++;
                        rx_q.push_back(mon_byte);
                        check("stop_bit", 32'(o_tx), 32'd1);
                        if (exp_byte_q.size() == 0) check("unexpected_frame", 32'(mon_byte), 32'hx);
                        else check("frame_byte", 32'(mon_byte), 32'(exp_byte_q.pop_front()));
                    end else if (mon_cnt == 99) begin
                        check("stop_end", 32'(o_tx), 32'd1);
                        mon_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] base, input logic [7:0] h, input logic [7:0] w);
        @(posedge clk);
        #1;
        i_start     = 1'b1;
        i_base_addr = base;
        i_h         = h;
        i_w         = w;
        @(posedge clk);
        #1;
        i_start     = 1'b0;
        i_base_addr = $urandom;
        i_h         = 8'($urandom);
        i_w         = 8'($urandom);
    endtask

    task automatic wait_cycle(input int unsigned target);
        for (int k = 0; k < 2000; k++) begin
            if (cyc == target) break;
            @(posedge clk);
            #1;
        end
        check("wait_cycle", cyc, target);
    endtask

    task automatic push_expected(input logic [31:0] base, input int unsigned n);
        logic [31:0] a;
        for (int unsigned i = 0; i < n; i++) begin
            a = base + i;
            exp_addr_q.push_back(a);
            exp_byte_q.push_back(a[7:0] ^ 8'hA5);
        end
    endtask

    task automatic run(input vec_t v);
        int unsigned n;
        int unsigned s;
        int unsigned f0, r0, b0, d0;
        bit          got;
        n = int'(v.h) * int'(v.w);
        push_expected(v.base, n);
        rx_q.delete();
        fstart_q.delete();
        f0 = frame_cnt;
        r0 = rd_cnt;
        b0 = busy_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        s = cyc + 1;
        pulse_start(v.base, v.h, v.w);
        if (v.mode == 1) begin
            repeat (250) @(posedge clk);
            #1;
            i_start = 1'b1;
            i_base_addr = 32'h50;
            i_h = 8'd1;
            i_w = 8'd1;
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end else if (v.mode == 2) begin
            wait_cycle(s + 1 + FRAME_PERIOD * v.exp_n);
            i_start = 1'b1;
            i_base_addr = 32'h60;
            i_h = 8'd1;
            i_w = 8'd1;
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < int'(FRAME_PERIOD * n + 30); k++) begin
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_latency", done_cyc - s, 1 + FRAME_PERIOD * v.exp_n);
        repeat (5) @(negedge clk);
        check("frames", frame_cnt - f0, v.exp_n);
        check("reads", rd_cnt - r0, v.exp_n);
        check("busy_cycles", busy_cnt - b0, FRAME_PERIOD * v.exp_n);
        check("done_pulses", done_cnt - d0, 32'd1);
        check("bytes_left", exp_byte_q.size(), 32'd0);
        for (int i = 1; i < fstart_q.size(); i++) begin
            check("frame_spacing", fstart_q[i] - fstart_q[i-1], FRAME_PERIOD);
        end
        if (v.exp_n > 0 && fstart_q.size() > 0 && rx_q.size() > 0) begin
            check("first_frame_delay", fstart_q[0] - s, 32'd3);
            check("first_byte", 32'(rx_q[0]), 32'(v.exp_first));
            check("addr_hold", o_mem_addr, v.base + v.exp_n - 1);
        end
        exp_addr_q.delete();
        exp_byte_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int unsigned s;

        vecs[0] = '{base: 32'h10,       h: 8'd1, w: 8'd1, mode: 0, exp_n: 1, exp_first: 8'hB5};
        vecs[1] = '{base: 32'h20,       h: 8'd2, w: 8'd3, mode: 0, exp_n: 6, exp_first: 8'h85};
        vecs[2] = '{base: 32'h0,        h: 8'd0, w: 8'd7, mode: 0, exp_n: 0, exp_first: 8'h00};
        vecs[3] = '{base: 32'h20,       h: 8'd2, w: 8'd3, mode: 1, exp_n: 6, exp_first: 8'h85};
        vecs[4] = '{base: 32'hFFFFFFFF, h: 8'd1, w: 8'd2, mode: 0, exp_n: 2, exp_first: 8'h5A};
        vecs[5] = '{base: 32'h40,       h: 8'd5, w: 8'd0, mode: 0, exp_n: 0, exp_first: 8'h00};
        vecs[6] = '{base: 32'h33,       h: 8'd3, w: 8'd1, mode: 2, exp_n: 3, exp_first: 8'h96};

        // Reset state while held, then 50 idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {28'd0, o_tx, o_busy, o_done, o_mem_r_en}, 32'h8);
        check("reset_addr", o_mem_addr, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_outputs", {28'd0, o_tx, o_busy, o_done, o_mem_r_en}, 32'h8);
        end
        check("idle_addr", o_mem_addr, 32'd0);

        for (int i = 0; i < 7; i++) run(vecs[i]);

        // Reset during bit 3 of the second byte (0x84, bit 3 = 0).
        push_expected(32'h20, 6);
        @(posedge clk);
        #1;
        s = cyc + 1;
        pulse_start(32'h20, 8'd2, 8'd3);
        wait_cycle(s + 105 + 45);
        @(negedge clk);
        check("pre_reset_tx", 32'(o_tx), 32'd0);
        check("pre_reset_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset_tx", 32'(o_tx), 32'd1);
        check("async_reset_busy", 32'(o_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr_q.delete();
        exp_byte_q.delete();
        repeat (20) @(negedge clk);
        check("post_reset_idle", {28'd0, o_tx, o_busy, o_done, o_mem_r_en}, 32'h8);
        run(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
